// File: rtl/kd_mod_mul.sv
`default_nettype none
// ============================================================================
// Module      : kd_mod_mul
// Description : Pipelined Barrett modular multiplier that feeds the butterfly
//               adder stage. In Kyber mode it runs two independent 12-bit
//               lanes mod 3329. In Dilithium mode it runs one 24-bit lane
//               mod 8380417. A sideband tag travels with each operand pair.
//               An operand pair sampled at edge N is presented after edge
//               N+4.
// Revision    : 1.0 - initial release
// ============================================================================
module kd_mod_mul #(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             kd_mode,
    input  logic [23:0]      mul_a,
    input  logic [23:0]      mul_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic             out_mode,
    output logic [23:0]      mul_p,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [12:0] KQ  = 13'd3329;
    localparam logic [23:0] DQ  = 24'd8380417;
    localparam logic [12:0] KM  = 13'd5039;
    localparam logic [23:0] DM  = 24'd8396807;
    localparam int          LAT = 4;

    // Stage 0: registered operands
    logic             r_s0_valid;
    logic             r_s0_mode;
    logic [TAG_W-1:0] r_s0_tag;
    logic [23:0]      r_s0_a;
    logic [23:0]      r_s0_b;

    // Stage 1: raw products. Kyber {xH,xL} as 2x24 bits, Dilithium x in [45:0]
    logic             r_s1_valid;
    logic             r_s1_mode;
    logic [TAG_W-1:0] r_s1_tag;
    logic [47:0]      r_s1_x;
    logic [47:0]      w_prod;

    // Stage 2: quotient estimate plus the product bits the remainder needs.
    // Kyber keeps xH[12:0] at [36:24] and xL[12:0] at [12:0]; Dilithium
    // keeps x[23:0] at [23:0].
    logic             r_s2_valid;
    logic             r_s2_mode;
    logic [TAG_W-1:0] r_s2_tag;
    logic [36:0]      r_s2_x;
    logic [23:0]      r_s2_t;
    logic [23:0]      w_quot;

    // Stage 3: partial remainder in [0, 2q). Kyber {rH,rL} as 2x13 bits,
    // Dilithium r in [23:0].
    logic             r_s3_valid;
    logic             r_s3_mode;
    logic [TAG_W-1:0] r_s3_tag;
    logic [25:0]      r_s3_r;
    logic [25:0]      w_rem;

    // Stage 4: fully reduced result driving the outputs
    logic             r_s4_valid;
    logic             r_s4_mode;
    logic [TAG_W-1:0] r_s4_tag;
    logic [23:0]      r_s4_p;
    logic [23:0]      w_res;

    // The latency constant documents the depth of the register chain below.
    if (LAT != 4) begin : g_lat_guard
        $error("kd_mod_mul pipeline depth is fixed at 4 stages after capture");
    end

    // Capture operands; data registers only load on a valid input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_mode  <= 1'b0;
            r_s0_tag   <= '0;
            r_s0_a     <= 24'd0;
            r_s0_b     <= 24'd0;
        end else begin
            r_s0_valid <= in_valid;
            if (in_valid) begin
                r_s0_mode <= kd_mode;
                r_s0_tag  <= in_tag;
                r_s0_a    <= mul_a;
                r_s0_b    <= mul_b;
            end
        end
    end

    // Raw product: per-lane 12x12 in Kyber, one 24x24 in Dilithium.
    always_comb begin
        w_prod = 48'd0;
        if (r_s0_mode) begin
            w_prod = {2'b00, 46'(r_s0_a) * 46'(r_s0_b)};
        end else begin
            w_prod = {24'(r_s0_a[23:12]) * 24'(r_s0_b[23:12]),
                      24'(r_s0_a[11:0])  * 24'(r_s0_b[11:0])};
        end
    end

    // Register the raw product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_tag   <= '0;
            r_s1_x     <= 48'd0;
        end else begin
            r_s1_valid <= r_s0_valid;
            if (r_s0_valid) begin
                r_s1_mode <= r_s0_mode;
                r_s1_tag  <= r_s0_tag;
                r_s1_x    <= w_prod;
            end
        end
    end

    // Barrett quotient estimate; it undershoots floor(x/q) by at most one.
    always_comb begin
        w_quot = 24'd0;
        if (r_s1_mode) begin
            w_quot = 24'((70'(r_s1_x[45:0]) * 70'(DM)) >> 46);
        end else begin
            w_quot = {12'((37'(r_s1_x[47:24]) * 37'(KM)) >> 24),
                      12'((37'(r_s1_x[23:0])  * 37'(KM)) >> 24)};
        end
    end

    // Register the quotient and the low product bits kept for the remainder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_mode  <= 1'b0;
            r_s2_tag   <= '0;
            r_s2_x     <= 37'd0;
            r_s2_t     <= 24'd0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_mode <= r_s1_mode;
                r_s2_tag  <= r_s1_tag;
                r_s2_x    <= {r_s1_x[36:24], r_s1_x[23:0]};
                r_s2_t    <= w_quot;
            end
        end
    end

    // Partial remainder x - t*q. The true value is below 2q, so only the
    // low q_bits+1 bits of each term are needed; lanes are computed separately
    // so no borrow crosses between them.
    always_comb begin
        w_rem = 26'd0;
        if (r_s2_mode) begin
            w_rem = {2'b00, r_s2_x[23:0] - r_s2_t * DQ};
        end else begin
            w_rem = {r_s2_x[36:24] - {1'b0, r_s2_t[23:12]} * KQ,
                     r_s2_x[12:0]  - {1'b0, r_s2_t[11:0]}  * KQ};
        end
    end

    // Register the partial remainder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
            r_s3_mode  <= 1'b0;
            r_s3_tag   <= '0;
            r_s3_r     <= 26'd0;
        end else begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_mode <= r_s2_mode;
                r_s3_tag  <= r_s2_tag;
                r_s3_r    <= w_rem;
            end
        end
    end

    // Single conditional subtract brings each lane into [0, q-1].
    always_comb begin
        w_res = 24'd0;
        if (r_s3_mode) begin
            w_res = (r_s3_r[23:0] >= DQ) ? (r_s3_r[23:0] - DQ) : r_s3_r[23:0];
        end else begin
            w_res = {12'((r_s3_r[25:13] >= KQ) ? (r_s3_r[25:13] - KQ) : r_s3_r[25:13]),
                     12'((r_s3_r[12:0]  >= KQ) ? (r_s3_r[12:0]  - KQ) : r_s3_r[12:0])};
        end
    end

    // Output register; holds the last result through bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s4_valid <= 1'b0;
            r_s4_mode  <= 1'b0;
            r_s4_tag   <= '0;
            r_s4_p     <= 24'd0;
        end else begin
            r_s4_valid <= r_s3_valid;
            if (r_s3_valid) begin
                r_s4_mode <= r_s3_mode;
                r_s4_tag  <= r_s3_tag;
                r_s4_p    <= w_res;
            end
        end
    end

    assign out_valid = r_s4_valid;
    assign out_mode  = r_s4_mode;
    assign out_tag   = r_s4_tag;
    assign mul_p     = r_s4_p;

endmodule
`default_nettype wire

// File: tb/tb_kd_mod_mul.sv
`default_nettype none
// ============================================================================
// Module      : tb_kd_mod_mul
// Description : Self-checking bench for kd_mod_mul. Every cycle the outputs
//               are compared with a plain-arithmetic modular reference of the
//               input accepted four edges earlier, or with the held values
//               when that slot was a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kd_mod_mul;

    localparam int      TAG_W = 8;
    localparam int      LAT   = 4;
    localparam longint  KQ    = 3329;
    localparam longint  DQ    = 8380417;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             kd_mode;
    logic [23:0]      mul_a;
    logic [23:0]      mul_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_mode;
    logic [23:0]      mul_p;
    logic [TAG_W-1:0] out_tag;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_outv = 0;
    int n      = 8;

    bit             rec_v [4096];
    bit             rec_m [4096];
    bit [23:0]      rec_p [4096];
    bit [TAG_W-1:0] rec_t [4096];

    bit [23:0]      hold_p = 24'd0;
    bit             hold_m = 1'b0;
    bit [TAG_W-1:0] hold_t = '0;

    kd_mod_mul #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .kd_mode   (kd_mode),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_mode  (out_mode),
        .mul_p     (mul_p),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: ordinary modular arithmetic on each lane.
    function automatic bit [23:0] ref_mul(input bit m, input bit [23:0] a, input bit [23:0] b);
        longint unsigned x;
        longint unsigned y;
        if (m) begin
            x = a;
            x = (x * b) % DQ;
            return x[23:0];
        end
        x = a[23:12];
        x = (x * b[23:12]) % KQ;
        y = a[11:0];
        y = (y * b[11:0]) % KQ;
        return {x[11:0], y[11:0]};
    endfunction

    function automatic bit [23:0] rand_op(input bit m);
        if (m) return 24'($urandom_range(0, 32'(DQ - 1)));
        return {12'($urandom_range(0, 32'(KQ - 1))), 12'($urandom_range(0, 32'(KQ - 1)))};
    endfunction

    // Drive one cycle, then check outputs against the slot LAT edges back.
    task automatic step(input bit v, input bit m, input bit [23:0] a, input bit [23:0] b,
                        input bit [TAG_W-1:0] t);
        in_valid = v;
        kd_mode  = m;
        mul_a    = a;
        mul_b    = b;
        in_tag   = t;
        @(posedge clk);
        n++;
        rec_v[n] = v;
        rec_m[n] = m;
        rec_p[n] = ref_mul(m, a, b);
        rec_t[n] = t;
        #1;
        if (out_valid === 1'b1) n_outv++;
        if (rec_v[n-LAT]) begin
            hold_p = rec_p[n-LAT];
            hold_m = rec_m[n-LAT];
            hold_t = rec_t[n-LAT];
        end
        check("out_valid", 64'(out_valid), 64'(rec_v[n-LAT]));
        check("mul_p",     64'(mul_p),     64'(hold_p));
        check("out_mode",  64'(out_mode),  64'(hold_m));
        check("out_tag",   64'(out_tag),   64'(hold_t));
    endtask

    task automatic idle();
        step(1'b0, 1'($urandom), 24'($urandom), 24'($urandom), TAG_W'($urandom));
    endtask

    initial begin
        bit m;
        rst      = 1'b1;
        in_valid = 1'b0;
        kd_mode  = 1'b0;
        mul_a    = 24'd0;
        mul_b    = 24'd0;
        in_tag   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_mul_p", 64'(mul_p),     64'd0);
        check("rst_mode",  64'(out_mode),  64'd0);
        check("rst_tag",   64'(out_tag),   64'd0);
        rst = 1'b0;

        // Directed lane, wrap and boundary cases.
        step(1'b0, 1'b0, 24'd0, 24'd0, 8'd0);
        step(1'b1, 1'b0, {12'd17, 12'd3328}, {12'd17, 12'd3328}, 8'hA5);
        repeat (LAT) idle();
        check("kyber_lanes", 64'(mul_p), 64'({12'd289, 12'd1}));
        step(1'b1, 1'b1, 24'd8380416, 24'd8380416, 8'h11);
        step(1'b1, 1'b1, 24'd4194304, 24'd2,       8'h12);
        step(1'b1, 1'b1, 24'd0,       24'd8380416, 8'h13);
        step(1'b1, 1'b0, {12'd3328, 12'd1}, {12'd1, 12'd3328}, 8'h14);
        step(1'b1, 1'b0, {12'd1, 12'd0},    {12'd1, 12'd0},    8'h15);
        step(1'b1, 1'b1, 24'd8380416, 24'd1, 8'h16);
        repeat (LAT + 2) idle();
        check("dil_last", 64'(mul_p), 64'd8380416);

        // Streaming, alternating modes, tags 0..199.
        n_outv = 0;
        for (int i = 0; i < 200; i++) begin
            m = 1'(i);
            step(1'b1, m, rand_op(m), rand_op(m), TAG_W'(i));
        end
        repeat (LAT + 2) idle();
        check("stream_count", 64'(n_outv), 64'd200);

        // Bubble pattern 1,0,0,1,1,0.
        step(1'b1, 1'b0, rand_op(1'b0), rand_op(1'b0), 8'd1);
        idle();
        idle();
        step(1'b1, 1'b1, rand_op(1'b1), rand_op(1'b1), 8'd2);
        step(1'b1, 1'b0, rand_op(1'b0), rand_op(1'b0), 8'd3);
        idle();
        repeat (LAT + 2) idle();

        // Reset with three pairs in flight.
        for (int i = 0; i < 3; i++) begin
            m = 1'($urandom);
            step(1'b1, m, rand_op(m), rand_op(m), TAG_W'(8'hC0 + i));
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_mul_p", 64'(mul_p),     64'd0);
        check("midrst_mode",  64'(out_mode),  64'd0);
        check("midrst_tag",   64'(out_tag),   64'd0);
        @(posedge clk);
        n++;
        #2;
        rst = 1'b0;
        for (int k = 0; k <= n; k++) rec_v[k] = 1'b0;
        hold_p = 24'd0;
        hold_m = 1'b0;
        hold_t = '0;
        step(1'b1, 1'b1, rand_op(1'b1), rand_op(1'b1), 8'hD0);
        repeat (LAT + 2) idle();

        // Random traffic with random bubbles and modes.
        for (int i = 0; i < 300; i++) begin
            m = 1'($urandom);
            if ($urandom_range(0, 3) != 0)
                step(1'b1, m, rand_op(m), rand_op(m), TAG_W'($urandom));
            else
                idle();
        end
        repeat (LAT + 2) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
